// File: rtl/led_sweep_ctrl.sv
// Bouncing one-hot LED controller with RUN/PAUSE/SWEEP/CLEAR command interface.
// Optional 16-bit saturating step counter when LED_SWEEP_CTRL_STEP_CNT_EN is defined.
module led_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 25000000
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] led,
  output logic             direction,
  output logic             step_en,
  output logic             busy
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
  ,
  output logic [15:0]      step_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SWEEP = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_PAUSE = 2'b01;
  localparam logic [1:0] OP_SWEEP = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int PW          = $clog2(CLK_DIV);
  localparam int SWEEP_STEPS = 2 * (WIDTH - 1);
  localparam int CW          = $clog2(SWEEP_STEPS + 1);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    SWEEP_END = CW'(SWEEP_STEPS);
  localparam logic [WIDTH-1:0] LED_INIT  = {1'b1, {(WIDTH-1){1'b0}}};

  // Bounce at the ends first, then shift; returns {direction, led}.
  function automatic logic [WIDTH:0] step_led(input logic [WIDTH-1:0] l, input logic d);
    logic nd;
    nd = d;
    if ((l[WIDTH-1] && !d) || (l[0] && d)) nd = !d;
    return nd ? {1'b1, l >> 1} : {1'b0, l << 1};
  endfunction

`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] cnt_q, cnt_d;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CW-1:0]    swcnt_q, swcnt_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] sv_led_q, sv_led_d;
  logic             sv_dir_q, sv_dir_d;
  logic             cmd_acc;
  logic             active;

  assign cmd_ready = (state_q != ST_SWEEP);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_SWEEP);
  assign led       = led_q;
  assign direction = dir_q;
  assign step_en   = step_q;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign active    = busy;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
  assign step_count = cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    dir_d    = dir_q;
    pre_d    = pre_q;
    swcnt_d  = swcnt_q;
    step_d   = 1'b0;
    sv_led_d = sv_led_q;
    sv_dir_d = sv_dir_q;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
    cnt_d    = cnt_q;
`endif
    // An accepted command freezes the prescaler and suppresses any step that cycle.
    if (cmd_acc) begin
      case (cmd_op)
        OP_RUN:   state_d = ST_RUN;
        OP_PAUSE: state_d = ST_PAUSE;
        OP_SWEEP: begin
          state_d  = ST_SWEEP;
          pre_d    = '0;
          swcnt_d  = '0;
          sv_led_d = led_q;
          sv_dir_d = dir_q;
        end
        default: begin
          state_d = ST_IDLE;
          led_d   = LED_INIT;
          dir_d   = 1'b0;
          pre_d   = '0;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
          cnt_d   = '0;
`endif
        end
      endcase
    end else if (state_q == ST_SWEEP && swcnt_q == SWEEP_END) begin
      state_d = ST_PAUSE;
      led_d   = sv_led_q;
      dir_d   = sv_dir_q;
    end else if (active) begin
      if (pre_q == PRE_LAST) begin
        pre_d          = '0;
        step_d         = 1'b1;
        {dir_d, led_d} = step_led(led_q, dir_q);
        if (state_q == ST_SWEEP) swcnt_d = swcnt_q + 1'b1;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
        cnt_d          = sat_inc(cnt_q);
`endif
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      led_q   <= LED_INIT;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      swcnt_q <= '0;
      step_q  <= 1'b0;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      swcnt_q <= swcnt_d;
      step_q  <= step_d;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Sweep-start snapshot is only read after being loaded, so it needs no reset.
  always_ff @(posedge inclk) begin
    sv_led_q <= sv_led_d;
    sv_dir_q <= sv_dir_d;
  end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Self-checking bench for led_sweep_ctrl: directed scenarios plus random commands
// compared every cycle against a position/direction reference model.
module tb_led_sweep_ctrl;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam logic [1:0] OP_RUN = 2'b00, OP_PAUSE = 2'b01, OP_SWEEP = 2'b10, OP_CLEAR = 2'b11;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SWEEP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic         cmd_ready;
  logic [W-1:0] led;
  logic         direction, step_en, busy;
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
  logic [15:0]  step_count;
`endif

  led_sweep_ctrl #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .inclk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .led(led), .direction(direction),
    .step_en(step_en), .busy(busy)
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
    , .step_count(step_count)
`endif
  );

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: LED as a bit index bouncing between 0 and W-1.
  int m_state, m_pos, m_pre, m_left, m_save_pos, m_cnt;
  bit m_dir, m_save_dir, m_step;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit [1:0] op);
    m_step = 1'b0;
    if (rst) begin
      m_state = S_IDLE; m_pos = W - 1; m_dir = 1'b0; m_pre = 0; m_left = 0; m_cnt = 0;
    end else if (v && m_state != S_SWEEP) begin
      case (op)
        OP_RUN:   m_state = S_RUN;
        OP_PAUSE: m_state = S_PAUSE;
        OP_SWEEP: begin
          m_state = S_SWEEP; m_pre = 0; m_left = 2 * (W - 1);
          m_save_pos = m_pos; m_save_dir = m_dir;
        end
        default: begin
          m_state = S_IDLE; m_pos = W - 1; m_dir = 1'b0; m_pre = 0; m_cnt = 0;
        end
      endcase
    end else if (m_state == S_SWEEP && m_left == 0) begin
      m_state = S_PAUSE; m_pos = m_save_pos; m_dir = m_save_dir;
    end else if (m_state == S_RUN || m_state == S_SWEEP) begin
      m_pre = m_pre + 1;
      if (m_pre == DIV) begin
        m_pre = 0;
        m_step = 1'b1;
        if ((!m_dir && m_pos == W - 1) || (m_dir && m_pos == 0)) m_dir = !m_dir;
        m_pos = m_dir ? m_pos - 1 : m_pos + 1;
        if (m_state == S_SWEEP) m_left = m_left - 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic tick(input bit rst, input bit v, input bit [1:0] op);
    @(negedge clk);
    reset = rst; cmd_valid = v; cmd_op = op;
    @(posedge clk);
    model_edge(rst, v, op);
    #1;
    check_val("led", led, 32'(1) << m_pos);
    check_val("direction", direction, m_dir);
    check_val("step_en", step_en, m_step);
    check_val("busy", busy, (m_state == S_RUN || m_state == S_SWEEP));
    check_val("cmd_ready", cmd_ready, (m_state != S_SWEEP));
`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
    check_val("step_count", step_count, m_cnt);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'($urandom_range(0, 3)));
  endtask

  // Cycles until step_en shows; budget+1 when it never does.
  task automatic wait_step(input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick(1'b0, 1'b0, 2'b00);
      if (step_en) begin
        n = i;
        break;
      end
    end
  endtask

  logic [7:0] seq [8];
  int n, pulses, bad;
  logic [W-1:0] led_before;

  initial begin
    seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    tick(1'b1, 1'b0, 2'b00);
    tick(1'b1, 1'b1, OP_RUN);
    check_val("rst_led", led, 8'h80);
    check_val("rst_dir", direction, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_step", step_en, 0);

    // RUN from reset: bounce sequence with a step every DIV cycles
    tick(1'b0, 1'b1, OP_RUN);
    for (int k = 0; k < 8; k++) begin
      wait_step(10, n);
      check_val("run_gap", n, DIV);
      check_val("run_led", led, seq[k]);
      if (k == 0) check_val("run_dir_first", direction, 1);
    end

    // PAUSE two cycles into a period, then RUN resumes mid-period
    idle(2);
    tick(1'b0, 1'b1, OP_PAUSE);
    idle(3);
    tick(1'b0, 1'b1, OP_RUN);
    wait_step(10, n);
    check_val("resume_gap", n, 2);

    // PAUSE on the terminal-count cycle wins over the step
    idle(3);
    led_before = led;
    tick(1'b0, 1'b1, OP_PAUSE);
    check_val("term_pause_step", step_en, 0);
    check_val("term_pause_led", led, led_before);

    // SWEEP from IDLE
    tick(1'b0, 1'b1, OP_CLEAR);
    tick(1'b0, 1'b1, OP_SWEEP);
    pulses = 0; bad = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      tick(1'b0, 1'b1, 2'($urandom_range(0, 3)));
      if (step_en) pulses++;
      if (busy && cmd_ready) bad++;
    end
    check_val("sweep_pulses", pulses, 2 * (W - 1));
    check_val("sweep_ready_low", bad, 0);
    check_val("sweep_end_led", led, 8'h80);
    check_val("sweep_end_dir", direction, 0);
    check_val("sweep_end_busy", busy, 0);

    // Reset mid-SWEEP
    tick(1'b0, 1'b1, OP_CLEAR);
    tick(1'b0, 1'b1, OP_SWEEP);
    idle(9);
    tick(1'b1, 1'b0, 2'b00);
    check_val("midrst_led", led, 8'h80);
    check_val("midrst_ready", cmd_ready, 1);
    check_val("midrst_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 2'b00);
      if (step_en) pulses++;
    end
    check_val("midrst_no_step", pulses, 0);

`ifdef LED_SWEEP_CTRL_STEP_CNT_EN
    tick(1'b0, 1'b1, OP_CLEAR);
    tick(1'b0, 1'b1, OP_RUN);
    for (int k = 0; k < 3; k++) wait_step(10, n);
    check_val("cnt_after3", step_count, 3);
    tick(1'b0, 1'b1, OP_CLEAR);
    check_val("cnt_cleared", step_count, 0);
`endif

    // Random commands and occasional resets
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_sweep_ctrl.md
LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LED vector width, minimum 2.
REQ-002 SHALL have parameter CLK_DIV, default 25000000: inclk cycles per LED step, minimum 2.
REQ-003 SHALL have port inclk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-006 SHALL have port cmd_op, input, 2: command code. 00 RUN, 01 PAUSE, 10 SWEEP, 11 CLEAR.
REQ-007 SHALL have port cmd_ready, output, 1: the block can accept a command.
REQ-008 SHALL have port led, output, WIDTH: one-hot LED pattern.
REQ-009 SHALL have port direction, output, 1: 0 = shifting toward MSB, 1 = shifting toward LSB.
REQ-010 SHALL have port step_en, output, 1: one-cycle pulse, high in the cycle led updates.
REQ-011 SHALL have port busy, output, 1: high in state RUN or SWEEP.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE and SWEEP.
REQ-013 SHALL accept a command only in a cycle where cmd_valid and cmd_ready are both high.
REQ-014 SHALL drive cmd_ready high in every state except SWEEP.
REQ-015 SHALL handle accepted commands as follows:
- RUN: go to RUN.
- PAUSE: go to PAUSE.
- SWEEP: go to SWEEP, clear the prescaler and the sweep counter.
- CLEAR: go to IDLE; led = 1 followed by WIDTH-1 zeros (MSB set); direction = 0; prescaler = 0.
REQ-016 SHALL count the prescaler 0..CLK_DIV-1 and wrap, only in RUN or SWEEP.
REQ-017 SHALL hold the prescaler value in PAUSE and IDLE, so RUN resumes mid-period.
REQ-018 SHALL assert step_en for exactly one cycle when the prescaler is at CLK_DIV-1 in RUN or SWEEP, and update led and direction in that same edge.
REQ-019 SHALL apply the step rule:
- if (led[WIDTH-1] and direction==0) or (led[0] and direction==1), invert direction first;
- then shift led one place in the (possibly new) direction.
- led SHALL stay one-hot at all times.
REQ-020 SHALL, in SWEEP, perform exactly 2*(WIDTH-1) steps, then enter PAUSE in the cycle after the final step_en, restoring the led and direction held at sweep start.
REQ-021 SHALL let an accepted command win when it coincides with a terminal prescaler count: step_en stays low and led is unchanged that cycle.
REQ-022 SHALL treat RUN while in RUN, or PAUSE while in PAUSE, as a no-op with no prescaler change.
REQ-023 SHALL leave every output combinational-free of cmd_valid except cmd_ready, which depends on state only.

Reset
REQ-024 SHALL, on reset high at a rising edge, set: state IDLE; led = MSB set; direction 0; prescaler 0; sweep counter 0; step_en 0; busy 0; cmd_ready 1.
REQ-025 SHALL give reset priority over any command and any step, including mid-SWEEP; no step_en is produced in a reset cycle.

Configuration
REQ-026 SHALL, when macro LED_SWEEP_CTRL_STEP_CNT_EN is defined, add output step_count, 16 bits, with this behaviour:
- increments on each step_en;
- saturates at 0xFFFF;
- cleared by reset and by CLEAR.
REQ-027 SHALL, when LED_SWEEP_CTRL_STEP_CNT_EN is undefined, omit the step_count port and counter entirely; all other behaviour is identical.

Verification (CLK_DIV=4, WIDTH=8)
REQ-028 SHALL cover reset then RUN: led sequence 0x80 -> 0x40 -> 0x20 ... -> 0x01 -> 0x02, with step_en every 4 cycles and direction 1 after the first step.
REQ-029 SHALL cover PAUSE accepted 2 cycles into a period, then RUN: the first step_en arrives exactly 2 cycles after RUN is accepted.
REQ-030 SHALL cover SWEEP from IDLE: exactly 14 step_en pulses, cmd_ready low throughout, then state PAUSE with led=0x80, direction=0, busy 0.
REQ-031 SHALL cover a PAUSE command on a terminal-count cycle: no step_en and led unchanged.
REQ-032 SHALL cover reset asserted mid-SWEEP: the next cycle shows led=0x80, cmd_ready 1, busy 0, and no further step_en.
REQ-033 SHALL cover, with LED_SWEEP_CTRL_STEP_CNT_EN defined: after 3 steps, step_count=3; after CLEAR, step_count=0.
